// File: rtl/fetch_buffer_if.sv
// Instruction-memory request/response channel between the fetch buffer
// (master) and instruction memory (slave).
interface fetch_buffer_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch stage: issues PCF to instruction memory, collects in-order responses
// into a circular buffer and presents the head entry to decode.
module fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          PCF,
    output logic [31:0]          PCPlus4F,
    input  logic                 PCSrcE,
    output logic                 StallF,
    fetch_buffer_if.master       imem,
    input  logic                 StallD,
    output logic                 ValidD,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCD,
    output logic [31:0]          PCPlus4D
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] occ_reg, occ_next;
    logic [CW-1:0] unfilled_reg, unfilled_next;
    logic [CW-1:0] discard_reg, discard_next;

    logic [31:0] pc_reg     [DEPTH];
    logic [31:0] instr_reg  [DEPTH];
    logic        filled_reg [DEPTH];

    logic          pop;
    logic          issue;
    logic          rsp_write;
    logic [PW-1:0] fill_idx;
    logic [CW:0]   demand;

    // Filled slots always form a prefix from head, so the oldest unfilled
    // slot sits unfilled_reg entries behind the tail.
    assign fill_idx = tail_reg - unfilled_reg[PW-1:0];

    assign ValidD = rst_n & filled_reg[head_reg] & (occ_reg != '0) & !PCSrcE;
    assign pop    = ValidD & !StallD;

    // Outstanding-to-be-discarded responses still need slots' worth of credit.
    assign demand = {1'b0, occ_reg} - (CW+1)'(pop) + {1'b0, discard_reg};

    assign imem.imem_req_valid = rst_n & !PCSrcE & (demand < (CW+1)'(DEPTH));
    assign imem.imem_req_addr  = PCF;
    assign issue     = imem.imem_req_valid & imem.imem_req_ready;
    assign StallF    = !issue;
    assign PCPlus4F  = PCF + 32'd4;

    assign rsp_write = rst_n & imem.imem_rsp_valid & !PCSrcE &
                       (discard_reg == '0) & (unfilled_reg != '0);

    assign InstrD   = ValidD ? instr_reg[head_reg] : 32'h0000_0013;
    assign PCD      = ValidD ? pc_reg[head_reg] : 32'd0;
    assign PCPlus4D = ValidD ? pc_reg[head_reg] + 32'd4 : 32'd0;

    always_comb begin
        head_next     = head_reg + PW'(pop);
        tail_next     = tail_reg + PW'(issue);
        occ_next      = occ_reg + CW'(issue) - CW'(pop);
        unfilled_next = unfilled_reg + CW'(issue) - CW'(rsp_write);
        discard_next  = discard_reg;
        if (PCSrcE) begin
            head_next     = tail_reg;
            occ_next      = '0;
            unfilled_next = '0;
            // A response dropped in the flush cycle retires one outstanding fetch.
            discard_next  = discard_reg + unfilled_reg -
                            CW'(imem.imem_rsp_valid & ((discard_reg != '0) | (unfilled_reg != '0)));
        end else if (imem.imem_rsp_valid && discard_reg != '0) begin
            discard_next  = discard_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            occ_reg      <= '0;
            unfilled_reg <= '0;
            discard_reg  <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            occ_reg      <= occ_next;
            unfilled_reg <= unfilled_next;
            discard_reg  <= discard_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (!rst_n || PCSrcE) begin
                    filled_reg[gi] <= 1'b0;
                end else if (issue && tail_reg == PW'(gi)) begin
                    filled_reg[gi] <= 1'b0;
                end else if (rsp_write && fill_idx == PW'(gi)) begin
                    filled_reg[gi] <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (issue && tail_reg == PW'(gi)) begin
                    pc_reg[gi] <= PCF;
                end
                if (rsp_write && fill_idx == PW'(gi)) begin
                    instr_reg[gi] <= imem.imem_rsp_data;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: PC register and fixed-latency memory environment,
// queue-based reference model, directed scenarios then randomized traffic.
module tb_fetch_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        PCSrcE;
    logic        StallF;
    logic        StallD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    fetch_buffer_if imem ();

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PCF      (PCF),
        .PCPlus4F (PCPlus4F),
        .PCSrcE   (PCSrcE),
        .StallF   (StallF),
        .imem     (imem),
        .StallD   (StallD),
        .ValidD   (ValidD),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    ent_t        mq[$];
    pend_t       pend[$];
    int          mdisc;
    int          cyc;
    int          total;
    int          bad;
    int          mem_lat;
    logic [31:0] target;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0033;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        bit          exp_valid;
        bit          exp_pop;
        bit          exp_req;
        bit          rsp_v;
        bit          act_acc;
        bit          stall_seen;
        bit          found;
        int          unf;
        logic [31:0] rsp_d;
        logic [31:0] acc_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;

        if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = $urandom;
        end
        #2;

        exp_valid = rst_n && !PCSrcE && mq.size() > 0 && mq[0].filled;
        exp_pop   = exp_valid && !StallD;
        exp_req   = rst_n && !PCSrcE && (mq.size() - int'(exp_pop) + mdisc < DEPTH);
        exp_instr = 32'h0000_0013;
        exp_pc    = 32'd0;
        if (exp_valid) begin
            exp_instr = mq[0].instr;
            exp_pc    = mq[0].pc;
        end

        check("ValidD",    {31'd0, ValidD}, {31'd0, exp_valid});
        check("InstrD",    InstrD, exp_instr);
        check("PCD",       PCD, exp_pc);
        check("PCPlus4D",  PCPlus4D, exp_valid ? exp_pc + 32'd4 : 32'd0);
        check("req_valid", {31'd0, imem.imem_req_valid}, {31'd0, exp_req});
        check("req_addr",  imem.imem_req_addr, PCF);
        check("StallF",    {31'd0, StallF}, {31'd0, !(exp_req && imem.imem_req_ready)});
        check("PCPlus4F",  PCPlus4F, PCF + 32'd4);
        $display("cyc=%0d rst_n=%0b PCF=%h req=%0b rdy=%0b rsp=%0b flush=%0b stallD=%0b ValidD=%0b PCD=%h InstrD=%h",
                 cyc, rst_n, PCF, imem.imem_req_valid, imem.imem_req_ready, imem.imem_rsp_valid,
                 PCSrcE, StallD, ValidD, PCD, InstrD);

        rsp_v      = imem.imem_rsp_valid;
        rsp_d      = imem.imem_rsp_data;
        act_acc    = imem.imem_req_valid && imem.imem_req_ready;
        acc_addr   = imem.imem_req_addr;
        stall_seen = StallF;

        @(posedge clk);
        #1;

        if (!rst_n) begin
            mq.delete();
            mdisc = 0;
        end else if (PCSrcE) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            if (rsp_v) begin
                check("rsp_has_owner", {31'd0, (mdisc + unf) > 0}, 32'd1);
                if (mdisc + unf > 0) mdisc = mdisc + unf - 1;
            end else begin
                mdisc = mdisc + unf;
            end
            mq.delete();
        end else begin
            if (rsp_v) begin
                if (mdisc > 0) begin
                    mdisc--;
                end else begin
                    found = 1'b0;
                    foreach (mq[i]) begin
                        if (!found && !mq[i].filled) begin
                            mq[i].instr  = rsp_d;
                            mq[i].filled = 1'b1;
                            found = 1'b1;
                        end
                    end
                    check("rsp_has_slot", {31'd0, found}, 32'd1);
                end
            end
            if (exp_pop) void'(mq.pop_front());
            if (exp_req && imem.imem_req_ready) mq.push_back('{PCF, 32'd0, 1'b0});
        end

        if (!rst_n) begin
            pend.delete();
        end else begin
            if (rsp_v) void'(pend.pop_front());
            if (act_acc) pend.push_back('{acc_addr, cyc + mem_lat});
        end

        if (!rst_n)      PCF = 32'd0;
        else if (PCSrcE) PCF = target;
        else if (!stall_seen) PCF = PCF + 32'd4;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        PCSrcE  = 1'b0;
        StallD  = 1'b0;
        PCF     = 32'd0;
        target  = 32'd0;
        mem_lat = 1;
        mdisc   = 0;
        cyc     = 0;
        total   = 0;
        bad     = 0;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'd0;
        @(posedge clk);
        #1;

        // Reset with idle memory, then release with ready low
        run(3);
        rst_n = 1'b1;
        run(2);

        // Latency-1 streaming
        imem.imem_req_ready = 1'b1;
        run(12);

        // Decode back-pressure then release
        StallD = 1'b1;
        run(6);
        StallD = 1'b0;
        run(10);

        // Flush with two requests in flight
        mem_lat = 2;
        run(6);
        PCSrcE = 1'b1;
        target = 32'h0000_1000;
        tick();
        PCSrcE = 1'b0;
        run(10);

        // Flush coinciding with a response
        mem_lat = 1;
        run(5);
        PCSrcE = 1'b1;
        target = 32'h0000_2000;
        tick();
        PCSrcE = 1'b0;
        run(8);

        // Reset with a full buffer and outstanding requests
        mem_lat = 3;
        StallD  = 1'b1;
        run(8);
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        StallD = 1'b0;
        run(10);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            if (k % 50 == 0) mem_lat = int'($urandom_range(1, 4));
            imem.imem_req_ready = ($urandom_range(0, 3) != 0);
            StallD = ($urandom_range(0, 3) == 0);
            PCSrcE = ($urandom_range(0, 19) == 0);
            target = $urandom & 32'hFFFF_FFFC;
            rst_n  = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n  = 1'b1;
        PCSrcE = 1'b0;
        StallD = 1'b0;
        imem.imem_req_ready = 1'b1;
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch stage sitting directly downstream of the PC register. Issues PCF to instruction memory over a valid/ready request channel and collects in-order responses into a DEPTH-entry in-order buffer. Presents {InstrD, PCD, PCPlus4D, ValidD} to decode. Drives StallF so that PCF advances only when its fetch request is accepted. A taken branch/jump (PCSrcE) flushes all buffered and in-flight fetches.

## Interface
- DEPTH, 4, buffer slots; power of 2, ≥2. Sustained 1 instr/cycle requires DEPTH ≥ memory latency + 1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- PCF  in  32  current fetch PC from the PC register.
- PCPlus4F  out  32  PCF + 4 (combinational, mod 2^32).
- PCSrcE  in  1  redirect/flush from execute.
- StallF  out  1  hold PC register; equals !(imem_req_valid & imem_req_ready).
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address, equals PCF.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  instruction returned; strictly in request order, ≥1 cycle after acceptance.
- imem_rsp_data  in  32  returned instruction word.
- StallD  in  1  decode cannot consume this cycle.
- ValidD  out  1  head entry holds a returned instruction.
- InstrD  out  32  head instruction; 32'h0000_0013 (NOP) when ValidD=0.
- PCD  out  32  PC of head entry; 0 when ValidD=0.
- PCPlus4D  out  32  PCD + 4; 0 when ValidD=0.

## Operation
- Storage: DEPTH slots of {pc, instr, filled}, circular, with head pointer, tail pointer, and occupancy count (0..DEPTH). Plus discard_cnt (0..DEPTH).
- pop = ValidD & !StallD & !PCSrcE. It frees the head slot at the edge.
- Issue: imem_req_valid = rst_n & !PCSrcE & (occupancy - pop + discard_cnt < DEPTH).
- On an accepted request, allocate the tail slot with pc=PCF and filled=0, then advance the tail.
- Response, discard_cnt=0, no flush: write instr into the oldest unfilled slot and set filled=1.
- Response, discard_cnt>0 or PCSrcE: drop the data. If discard_cnt>0, decrement it.
- A response with no unfilled slot and discard_cnt=0 is a protocol error. Ignore it; the bench asserts it never occurs.
- Flush (PCSrcE=1) at the edge:
  - empty all slots (occupancy=0, head=tail);
  - discard_cnt <= (discard_cnt + unfilled allocated slots) minus 1 if a response is dropped this cycle.
  - No request is issued in the flush cycle, so StallF=1 and the redirected PCF is fetched next cycle.
- Outputs are driven combinationally from the head slot: ValidD = filled[head] & occupancy>0 & !PCSrcE.
- Request, response and pop may all occur in the same cycle. Occupancy updates by +issue −pop.

## Timing
- Reset (rst_n=0 at an edge):
  - occupancy, discard_cnt, head and tail clear to 0; filled bits clear.
  - While rst_n=0: imem_req_valid=0, StallF=1, ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=0.
- Reset mid-operation: all in-flight state is lost with no drain. The memory is reset with the same rst_n.
- Request to decode: a response arriving in cycle t is visible at ValidD in cycle t+1. With memory latency L, a request accepted in cycle c reaches decode no earlier than c+L+1.
- Full: when occupancy − pop + discard_cnt = DEPTH, imem_req_valid=0 and StallF=1. Issue resumes in the same cycle a pop makes room.
- Empty / unfilled head: ValidD=0 and decode sees a NOP.
- Pointers wrap mod DEPTH.

## Test plan
- Reset, then idle memory (ready=0): imem_req_valid=0 during reset and StallF=1 throughout, ValidD=0, InstrD=0x00000013. After rst_n=1: req_valid=1, req_addr=0x0.
- Latency-1 memory, ready=1, PC sequence 0x0,0x4,0x8…: ValidD=1 from cycle 2 onward, with one instruction per cycle and PCD, PCPlus4D, InstrD matching memory contents.
- StallD held high for 6 cycles: with latency 1, at most DEPTH(4) requests accepted, then StallF=1. On release, ValidD output is in order with no loss or duplication.
- PCSrcE pulse with 2 requests in flight: ValidD=0 in the flush cycle, and the next 2 responses are dropped. The first instruction shown after the flush has PCD equal to the new PCF target.
- Response arriving in the same cycle as PCSrcE: it is dropped and discard_cnt is reduced accordingly. Verify no stale instruction reaches decode.
- rst_n asserted with a full buffer and outstanding requests: the next cycle shows ValidD=0, occupancy=0, discard_cnt=0, and the fetch restarts at PCF=0x0.
